minibyte_fetch_unit: RTL and testbench
======================================

// Module: minibyte_fetch_unit
// PURPOSE
//  Instruction fetch sequencer for the minibyte CPU. On a start request it reads the opcode at the PC
//  over a req/ack memory handshake, then reads an operand byte if the opcode requires one. It drives
//  data plus set pulses into the IR and operand general registers, and increment pulses into the PC
//  register, one per fetched byte. Sits between the memory bus and the register file; the control unit
//  is upstream via start/done.
// PARAMETERS
//  OPR_BIT   7   opcode bit that, when 1, marks a two-byte instruction (operand fetch follows)
//  TO_W      4   width of the ack-timeout counter
//  TIMEOUT   15  cycles mem_req_out may wait for ack before abort; 0 = never time out
// PORTS
//  clk_in        in   1  system clock, rising edge
//  rst_in        in   1  asynchronous, active-low reset
//  start_in      in   1  begin a fetch; sampled only in IDLE
//  flush_in      in   1  synchronous abort to IDLE, priority over all other inputs except reset
//  pc_in         in   8  current PC (PC register reg_out)
//  mem_data_in   in   8  read data, valid in the cycle mem_ack_in=1
//  mem_ack_in    in   1  memory acknowledge
//  mem_req_out   out  1  read request, held until ack, timeout or flush
//  mem_addr_out  out  8  read address = pc_in (combinational)
//  data_out      out  8  fetched byte, drives IR/operand reg_in
//  ir_set_out    out  1  one-cycle set pulse to IR register
//  opr_set_out   out  1  one-cycle set pulse to operand register
//  pc_inc_out    out  1  one-cycle inc pulse to PC register
//  busy_out      out  1  1 in every state except IDLE
//  done_out      out  1  one-cycle pulse: fetch completed
//  err_out       out  1  one-cycle pulse: ack timeout, fetch abandoned
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0, data_out=0, timer=0. All outputs except mem_addr_out are registered.
//  - States: IDLE, REQ_OP, LATCH_OP, REQ_ARG, LATCH_ARG, DONE, ERR.
//  - IDLE: start_in=1 -> REQ_OP, mem_req_out=1 from the next cycle. start_in is ignored in all other states.
//  - REQ_OP: in the cycle mem_ack_in=1: data_out<=mem_data_in, latch opcode bit OPR_BIT internally,
//    mem_req_out<=0 -> LATCH_OP.
//  - LATCH_OP: ir_set_out=1 and pc_inc_out=1 for exactly this cycle. Next state is REQ_ARG if the latched
//    bit=1, else DONE.
//  - REQ_ARG: mem_req_out=1, address = incremented pc_in. Ack -> capture data_out -> LATCH_ARG.
//  - LATCH_ARG: opr_set_out=1 and pc_inc_out=1 for one cycle -> DONE.
//  - DONE: done_out=1 for one cycle -> IDLE.
//  - Latency with same-cycle ack: a 1-byte fetch is start -> done in 4 cycles; a 2-byte fetch takes 6.
//    Each ack wait cycle adds 1.
//  - Timeout: timer clears on entry to REQ_* and counts while req=1 and ack=0. If TIMEOUT!=0 and the timer
//    reaches TIMEOUT with no ack, mem_req_out<=0 -> ERR. No set or inc pulse is issued for that byte.
//    ERR: err_out=1 for one cycle -> IDLE.
//  - An ack in the same cycle the timer hits TIMEOUT wins (normal capture).
//  - An ack outside REQ_* is ignored.
//  - flush_in=1: next state IDLE, mem_req_out<=0, set/inc/done/err outputs <=0 at that edge. Pulses already
//    asserted in the flush cycle complete normally. data_out holds its value.
//  - Aborted fetch (flush or timeout) after LATCH_OP: the PC has advanced one byte. The control unit owns
//    recovery.
//  - pc_in must not be changed by any other source while busy_out=1; this block then never issues set and
//    inc in the same cycle.
//  - PC wrap 0xFF -> 0x00 is performed by the PC register; this block applies no special handling.
// STRUCTURE
//  - State encodings (3-bit localparams) and OPR_BIT default go in the shared minibyte_defs.vh header,
//    which the control unit also uses.
//  - One sub-module: minibyte_fetch_timer (clear, enable, TO_W count, expired flag).
//  - The FSM, data capture and pulse generation stay in this module.
// TESTING
//  - 1-byte fetch: pc=0x10, start, ack on first req cycle with data 0x05 -> ir_set+pc_inc on cycle 3,
//    data_out=0x05, opr_set never, done on cycle 4.
//  - 2-byte fetch: mem[0x10]=0x85, mem[0x11]=0x3C -> addrs 0x10 then 0x11, ir gets 0x85, opr gets 0x3C,
//    two pc_inc pulses, done at cycle 6.
//  - Wait states: ack delayed 3 cycles -> req held stable with addr stable; done shifts by 3; no early pulses.
//  - Timeout: TIMEOUT=4, never ack -> req drops after 4 wait cycles, err_out pulse, no pulses, returns to
//    IDLE. Ack on exactly cycle 4 -> normal capture.
//  - Flush during REQ_ARG -> req drops next edge, no opr_set, no done; one pc_inc seen in total;
//    start accepted 1 cycle later.
//  - Reset asserted mid-LATCH_ARG -> all outputs 0 asynchronously; start ignored while busy;
//    PC wrap 0xFF->0x00 fetches from 0x00.

Source files
------------

// File: rtl/minibyte_fetch_unit_pkg.sv
// Shared types for the minibyte fetch sequencer: state encoding, registered output bundle
// and the default parameter values used by the fetch unit and the control unit.
package minibyte_fetch_unit_pkg;

    localparam int OPR_BIT_DEFAULT = 7;
    localparam int TO_W_DEFAULT    = 4;
    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ_OP    = 3'd1,
        S_LATCH_OP  = 3'd2,
        S_REQ_ARG   = 3'd3,
        S_LATCH_ARG = 3'd4,
        S_DONE      = 3'd5,
        S_ERR       = 3'd6
    } fetch_state_e;

    typedef struct packed {
        logic req;
        logic ir_set;
        logic opr_set;
        logic pc_inc;
        logic busy;
        logic done;
        logic err;
    } fetch_out_t;

    function automatic logic is_req_state(input fetch_state_e s);
        return (s == S_REQ_OP) || (s == S_REQ_ARG);
    endfunction

endpackage

// File: rtl/minibyte_fetch_timer.sv
// Ack-wait timer: counts request cycles without an acknowledge and flags the cycle in which
// the count would reach LIMIT. LIMIT = 0 disables expiry.
module minibyte_fetch_timer #(
    parameter int TO_W  = 4,
    parameter int LIMIT = 15
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TO_W-1:0] LAST = TO_W'(LIMIT - 1);

    logic [TO_W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: default assignment first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the async reset clears the counter.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // An ack in the expiring cycle wins because enable_i is low whenever ack is present.
    assign expired_o = (LIMIT != 0) && enable_i && (count_q == LAST);

endmodule

// File: rtl/minibyte_fetch_unit.sv
// Instruction fetch sequencer: reads the opcode (and an operand byte when flagged) over a
// req/ack bus and emits registered set/inc pulses towards the IR, operand and PC registers.
module minibyte_fetch_unit
    import minibyte_fetch_unit_pkg::*;
#(
    parameter int OPR_BIT = OPR_BIT_DEFAULT,
    parameter int TO_W    = TO_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       start_in,
    input  logic       flush_in,
    input  logic [7:0] pc_in,
    input  logic [7:0] mem_data_in,
    input  logic       mem_ack_in,
    output logic       mem_req_out,
    output logic [7:0] mem_addr_out,
    output logic [7:0] data_out,
    output logic       ir_set_out,
    output logic       opr_set_out,
    output logic       pc_inc_out,
    output logic       busy_out,
    output logic       done_out,
    output logic       err_out
);

    fetch_state_e state_q, state_d;
    fetch_out_t   out_q, out_d;
    logic [7:0]   data_q, data_d;
    logic         two_byte_q, two_byte_d;
    logic         in_req, expired, capture;

    assign in_req  = is_req_state(state_q);
    assign capture = in_req && mem_ack_in && !flush_in;

    minibyte_fetch_timer #(
        .TO_W  (TO_W),
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear_i   (!in_req),
        .enable_i  (in_req && !mem_ack_in),
        .expired_o (expired)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            out_q      <= '0;
            data_q     <= '0;
            two_byte_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            data_q     <= data_d;
            two_byte_q <= two_byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_in) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:      if (start_in) state_d = S_REQ_OP;
                S_REQ_OP:    if (mem_ack_in) state_d = S_LATCH_OP;
                             else if (expired) state_d = S_ERR;
                S_LATCH_OP:  state_d = two_byte_q ? S_REQ_ARG : S_DONE;
                S_REQ_ARG:   if (mem_ack_in) state_d = S_LATCH_ARG;
                             else if (expired) state_d = S_ERR;
                S_LATCH_ARG: state_d = S_DONE;
                S_DONE:      state_d = S_IDLE;
                S_ERR:       state_d = S_IDLE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so each pulse is registered for the state it marks.
    always_comb begin
        out_d         = '0;
        out_d.req     = is_req_state(state_d);
        out_d.ir_set  = (state_d == S_LATCH_OP);
        out_d.opr_set = (state_d == S_LATCH_ARG);
        out_d.pc_inc  = (state_d == S_LATCH_OP) || (state_d == S_LATCH_ARG);
        out_d.busy    = (state_d != S_IDLE);
        out_d.done    = (state_d == S_DONE);
        out_d.err     = (state_d == S_ERR);
    end

    always_comb begin
        data_d     = data_q;
        two_byte_d = two_byte_q;
        if (capture) begin
            data_d = mem_data_in;
            if (state_q == S_REQ_OP) begin
                two_byte_d = mem_data_in[OPR_BIT];
            end
        end
    end

    assign mem_addr_out = pc_in;
    assign data_out     = data_q;
    assign mem_req_out  = out_q.req;
    assign ir_set_out   = out_q.ir_set;
    assign opr_set_out  = out_q.opr_set;
    assign pc_inc_out   = out_q.pc_inc;
    assign busy_out     = out_q.busy;
    assign done_out     = out_q.done;
    assign err_out      = out_q.err;

endmodule

// File: tb/tb_minibyte_fetch_unit.sv
// Self-checking bench for minibyte_fetch_unit: a per-cycle expected timeline is built from the
// fetch rules (bytes, wait states, timeout) and compared against the DUT every cycle.
module tb_minibyte_fetch_unit;

    localparam int TMO = 4;

    // flag order: req, ir_set, opr_set, pc_inc, busy, done, err
    localparam logic [6:0] F_IDLE = 7'b0000000;
    localparam logic [6:0] F_REQ  = 7'b1000100;
    localparam logic [6:0] F_IR   = 7'b0101100;
    localparam logic [6:0] F_OPR  = 7'b0011100;
    localparam logic [6:0] F_DONE = 7'b0000110;
    localparam logic [6:0] F_ERR  = 7'b0000101;

    typedef struct packed {
        logic [6:0] f;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    logic       clk_in      = 1'b0;
    logic       rst_in      = 1'b0;
    logic       start_in    = 1'b0;
    logic       flush_in    = 1'b0;
    logic       mem_ack_in  = 1'b0;
    logic [7:0] pc_in       = 8'h00;
    logic [7:0] mem_data_in = 8'h00;
    logic       mem_req_out, ir_set_out, opr_set_out, pc_inc_out, busy_out, done_out, err_out;
    logic [7:0] mem_addr_out, data_out;

    logic [7:0] mem [256];
    exp_t       exp_q [$];
    logic [7:0] exp_data = 8'h00;
    int         n_vec = 0;
    int         n_err = 0;
    int         req_cnt = 0;
    int         byte_i = 0;

    minibyte_fetch_unit #(
        .OPR_BIT (7),
        .TO_W    (4),
        .TIMEOUT (TMO)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (start_in),
        .flush_in     (flush_in),
        .pc_in        (pc_in),
        .mem_data_in  (mem_data_in),
        .mem_ack_in   (mem_ack_in),
        .mem_req_out  (mem_req_out),
        .mem_addr_out (mem_addr_out),
        .data_out     (data_out),
        .ir_set_out   (ir_set_out),
        .opr_set_out  (opr_set_out),
        .pc_inc_out   (pc_inc_out),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .err_out      (err_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed=hung expected=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] obs_flags();
        return {mem_req_out, ir_set_out, opr_set_out, pc_inc_out, busy_out, done_out, err_out};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input logic [6:0] f, input logic [7:0] a,
                               input logic [7:0] d);
        check({tag, ".flags"}, 32'(obs_flags()), 32'(f));
        if (f[6]) check({tag, ".addr"}, 32'(mem_addr_out), 32'(a));
        check({tag, ".data"}, 32'(data_out), 32'(d));
    endtask

    // One clock; the environment's PC register advances on an inc pulse seen before the edge.
    task automatic step();
        logic inc;
        inc = pc_inc_out;
        @(posedge clk_in);
        #1;
        if (inc) pc_in = pc_in + 8'd1;
    endtask

    // Memory model: acks the request after w wait cycles; stray acks outside requests.
    task automatic respond(input int w0, input int w1);
        int target;
        target = (byte_i == 0) ? w0 : w1;
        if (mem_req_out) begin
            if (req_cnt == target) begin
                mem_ack_in  = 1'b1;
                mem_data_in = mem[mem_addr_out];
                byte_i++;
                req_cnt = 0;
            end else begin
                mem_ack_in  = 1'b0;
                mem_data_in = 8'($urandom);
                req_cnt++;
            end
        end else begin
            mem_ack_in  = 1'($urandom_range(0, 1));
            mem_data_in = 8'($urandom);
            req_cnt     = 0;
        end
    endtask

    task automatic add_phase(input logic [7:0] addr, input int w, input logic [7:0] d,
                             output bit timed_out);
        int n;
        timed_out = (w >= TMO);
        n = timed_out ? TMO : w + 1;
        for (int i = 0; i < n; i++) exp_q.push_back(exp_t'({F_REQ, addr, d}));
        if (timed_out) exp_q.push_back(exp_t'({F_ERR, 8'h00, d}));
    endtask

    task automatic build_fetch(input logic [7:0] pc0, input int w0, input int w1,
                               output logic [7:0] d_final);
        logic [7:0] d, op, arg, pc1;
        bit         to;
        pc1 = pc0 + 8'd1;
        d   = exp_data;
        op  = mem[pc0];
        arg = mem[pc1];
        add_phase(pc0, w0, d, to);
        if (!to) begin
            d = op;
            exp_q.push_back(exp_t'({F_IR, 8'h00, d}));
            if (op[7]) begin
                add_phase(pc1, w1, d, to);
                if (!to) begin
                    d = arg;
                    exp_q.push_back(exp_t'({F_OPR, 8'h00, d}));
                end
            end
            if (!to) exp_q.push_back(exp_t'({F_DONE, 8'h00, d}));
        end
        exp_q.push_back(exp_t'({F_IDLE, 8'h00, d}));
        d_final = d;
    endtask

    task automatic run_fetch(input logic [7:0] pc0, input int w0, input int w1, input bit hold_start);
        logic [7:0] d_final;
        exp_t       e;
        int         c;
        pc_in      = pc0;
        mem_ack_in = 1'b0;
        exp_q.delete();
        build_fetch(pc0, w0, w1, d_final);
        start_in = 1'b1;
        step();
        req_cnt = 0;
        byte_i  = 0;
        c       = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            start_in = hold_start && e.f[2];
            respond(w0, w1);
            check_cycle($sformatf("fetch pc=%02h c%0d", pc0, c), e.f, e.addr, e.data);
            step();
            c++;
        end
        exp_data   = d_final;
        start_in   = 1'b0;
        mem_ack_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            mem_ack_in  = 1'($urandom_range(0, 1));
            mem_data_in = 8'($urandom);
            check_cycle("idle", F_IDLE, 8'h00, exp_data);
            step();
        end
        mem_ack_in = 1'b0;
    endtask

    initial begin
        logic [7:0] pc0, op;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        // reset state
        pc_in = 8'h10;
        #12;
        check_cycle("reset", F_IDLE, 8'h00, 8'h00);
        check("reset.addr", 32'(mem_addr_out), 32'h10);
        @(negedge clk_in) rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        idle(2);

        // 1-byte fetch
        mem[8'h10] = 8'h05;
        run_fetch(8'h10, 0, 0, 1'b0);
        idle(1);

        // 2-byte fetch
        mem[8'h10] = 8'h85;
        mem[8'h11] = 8'h3C;
        run_fetch(8'h10, 0, 0, 1'b0);

        // wait states, start held high while busy
        run_fetch(8'h10, 3, 3, 1'b1);
        mem[8'h20] = 8'h11;
        run_fetch(8'h20, 3, 0, 1'b1);

        // timeout on opcode, ack in the expiring cycle, timeout on operand
        mem[8'h30] = 8'h42;
        run_fetch(8'h30, 100, 0, 1'b0);
        run_fetch(8'h30, TMO - 1, 0, 1'b0);
        mem[8'h50] = 8'hA0;
        run_fetch(8'h50, 0, 100, 1'b0);
        idle(1);

        // flush during REQ_ARG, then start in the very next cycle
        pc0 = 8'h60;
        op  = 8'h9A;
        mem[pc0] = op;
        pc_in = pc0;
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        mem_ack_in = 1'b1;
        mem_data_in = op;
        check_cycle("flush.req_op", F_REQ, pc0, exp_data);
        step();
        mem_ack_in = 1'b0;
        check_cycle("flush.latch_op", F_IR, 8'h00, op);
        step();
        check_cycle("flush.req_arg", F_REQ, 8'h61, op);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        check_cycle("flush.idle", F_IDLE, 8'h00, op);
        check("flush.pc_total", 32'(pc_in), 32'h61);
        exp_data = op;
        mem[8'h61] = 8'h07;
        run_fetch(8'h61, 0, 0, 1'b0);

        // asynchronous reset in the middle of LATCH_ARG
        mem[8'h40] = 8'hC1;
        mem[8'h41] = 8'h77;
        pc_in = 8'h40;
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        mem_ack_in = 1'b1;
        mem_data_in = 8'hC1;
        check_cycle("rst.req_op", F_REQ, 8'h40, exp_data);
        step();
        mem_ack_in = 1'b0;
        check_cycle("rst.latch_op", F_IR, 8'h00, 8'hC1);
        step();
        mem_ack_in = 1'b1;
        mem_data_in = 8'h77;
        check_cycle("rst.req_arg", F_REQ, 8'h41, 8'hC1);
        step();
        mem_ack_in = 1'b0;
        check_cycle("rst.latch_arg", F_OPR, 8'h00, 8'h77);
        #2 rst_in = 1'b0;
        #1;
        check_cycle("rst.async", F_IDLE, 8'h00, 8'h00);
        @(negedge clk_in) rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        exp_data = 8'h00;
        idle(1);

        // PC wrap: opcode at 0xFF, operand at 0x00
        mem[8'hFF] = 8'hF0;
        mem[8'h00] = 8'h5A;
        run_fetch(8'hFF, 1, 2, 1'b0);

        // randomized fetches, including timeouts on either byte
        for (int t = 0; t < 24; t++) begin
            run_fetch(8'($urandom), $urandom_range(0, 5), $urandom_range(0, 5),
                      1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
